// File: rtl/adder_sched_pkg.sv
// Shared types and constants for the round-robin adder scheduler.
package adder_sched_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_e;

    localparam int OPW  = 4;
    localparam int SUMW = 5;

    function automatic int id_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority one-hot picker: first set request at or after ptr_i.
module rr_pick
    import adder_sched_pkg::*;
#(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic [N-1:0]   req_i,
    input  logic [IDW-1:0] ptr_i,
    output logic [N-1:0]   gnt_o,
    output logic [IDW-1:0] idx_o,
    output logic           any_o
);

    int j;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        j     = 0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr_i) + k) % N;
            if (!any_o && req_i[IDW'(j)]) begin
                any_o               = 1'b1;
                gnt_o[IDW'(j)]      = 1'b1;
                idx_o               = IDW'(j);
            end
        end
    end

endmodule

// File: rtl/adder_rr_scheduler.sv
// Round-robin front end sharing one 4-bit adder among NUM_REQ requesters,
// one operation in flight, tagged result on a valid/ready response port.
module adder_rr_scheduler
    import adder_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADD_LAT = 1,
    parameter int IDW     = id_width(NUM_REQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ*OPW-1:0] req_a,
    input  logic [NUM_REQ*OPW-1:0] req_b,
    input  logic [NUM_REQ-1:0]     req_cin,
    output logic [OPW-1:0]         add_a,
    output logic [OPW-1:0]         add_b,
    output logic                   add_cin,
    input  logic [SUMW-1:0]        add_sum,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [IDW-1:0]         rsp_id,
    output logic [SUMW-1:0]        rsp_sum
);

    localparam int CW = id_width(ADD_LAT + 1);

    state_e          state_q;
    logic [IDW-1:0]  ptr_q;
    logic [IDW-1:0]  ptr_d;
    logic [CW-1:0]   cnt_q;
    logic [OPW-1:0]  add_a_q;
    logic [OPW-1:0]  add_b_q;
    logic            add_cin_q;
    logic            rsp_valid_q;
    logic [IDW-1:0]  rsp_id_q;
    logic [SUMW-1:0] rsp_sum_q;

    logic [NUM_REQ-1:0] gnt;
    logic [IDW-1:0]     gidx;
    logic               any;

    rr_pick #(
        .N   (NUM_REQ),
        .IDW (IDW)
    ) u_pick (
        .req_i (req_valid),
        .ptr_i (ptr_q),
        .gnt_o (gnt),
        .idx_o (gidx),
        .any_o (any)
    );

    assign ptr_d = (int'(gidx) == NUM_REQ - 1) ? '0 : gidx + 1'b1;

    // Grant is only visible while idle and out of reset.
    assign req_ready = (state_q == S_IDLE && rst_n) ? gnt : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            cnt_q       <= '0;
            add_a_q     <= '0;
            add_b_q     <= '0;
            add_cin_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_sum_q   <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (any) begin
                        add_a_q   <= req_a[gidx*OPW +: OPW];
                        add_b_q   <= req_b[gidx*OPW +: OPW];
                        add_cin_q <= req_cin[gidx];
                        rsp_id_q  <= gidx;
                        ptr_q     <= ptr_d;
                        cnt_q     <= CW'(ADD_LAT);
                        state_q   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt_q == '0) begin
                        rsp_sum_q   <= add_sum;
                        rsp_valid_q <= 1'b1;
                        state_q     <= S_RESP;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign add_a     = add_a_q;
    assign add_b     = add_b_q;
    assign add_cin   = add_cin_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_sum   = rsp_sum_q;

endmodule

// File: tb/tb_adder_rr_scheduler.sv
// Scoreboard bench for adder_rr_scheduler with a one-cycle registered adder.
module tb_adder_rr_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic [3:0]  req_cin;
    logic [3:0]  add_a;
    logic [3:0]  add_b;
    logic        add_cin;
    logic [4:0]  add_sum = '0;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [4:0]  rsp_sum;

    typedef struct {
        logic [1:0] id;
        logic [4:0] sum;
    } exp_t;

    exp_t       exp_q[$];
    logic [3:0] glog[$];
    int         gcyc[$];
    int         n_chk  = 0;
    int         n_pass = 0;
    int         cyc    = 0;
    logic [3:0] hs;

    always #5 clk = ~clk;

    adder_rr_scheduler #(
        .NUM_REQ (4),
        .ADD_LAT (1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_cin   (add_cin),
        .add_sum   (add_sum),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum)
    );

    always @(posedge clk)
        add_sum <= {1'b0, add_a} + {1'b0, add_b} + {4'b0, add_cin};

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("rsp_unexpected", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("rsp_id", 32'(rsp_id), 32'(e.id));
                chk("rsp_sum", 32'(rsp_sum), 32'(e.sum));
            end
        end
    end

    // One cycle: sample handshake at negedge, retire accepted requests after edge.
    task automatic tick();
        @(negedge clk);
        hs = req_valid & req_ready;
        if (hs != 0) begin
            glog.push_back(hs);
            gcyc.push_back(cyc);
        end
        @(posedge clk);
        #1;
        cyc++;
        req_valid = req_valid & ~hs;
    endtask

    task automatic post(input int i, input logic [3:0] a,
                        input logic [3:0] b, input logic c);
        req_a[i*4 +: 4] = a;
        req_b[i*4 +: 4] = b;
        req_cin[i]      = c;
        req_valid[i]    = 1'b1;
    endtask

    task automatic expect_rsp(input logic [1:0] id, input logic [4:0] sum);
        exp_t e;
        e.id  = id;
        e.sum = sum;
        exp_q.push_back(e);
    endtask

    task automatic wait_drain(input string nm, input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || req_valid != 0 || rsp_valid) && n < budget) begin
            tick();
            n++;
        end
        chk(nm, 32'(n < budget), 32'd1);
    endtask

    task automatic wait_grants(input string nm, input int cnt, input int budget);
        int n;
        n = 0;
        while (glog.size() < cnt && n < budget) begin
            tick();
            n++;
        end
        chk(nm, 32'(glog.size() >= cnt), 32'd1);
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_cin   = '0;
        rsp_ready = 1'b1;

        #2;
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_add", 32'({add_a, add_b, add_cin}), 32'd0);
        chk("rst_rsp", 32'({rsp_id, rsp_sum}), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("idle_req_ready", 32'(req_ready), 32'd0);
        end

        // Single request from requester 1: 13 + 5 = 18
        post(1, 4'b1101, 4'b0101, 1'b0);
        expect_rsp(2'd1, 5'b10010);
        tick();
        chk("single_grant", 32'(glog.size() == 1 ? glog[0] : 4'hx), 32'b0010);
        chk("single_lat0", 32'(rsp_valid), 32'd0);
        tick();
        chk("single_lat1", 32'(rsp_valid), 32'd0);
        tick();
        chk("single_lat2", 32'(rsp_valid), 32'd1);
        wait_drain("single_drain", 20);
        chk("single_one_grant", 32'(glog.size()), 32'd1);

        // Round robin from a fresh pointer
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        glog.delete();
        gcyc.delete();
        post(0, 4'b0011, 4'b0100, 1'b0);
        post(1, 4'b1000, 4'b1000, 1'b0);
        post(2, 4'b1010, 4'b0110, 1'b1);
        post(3, 4'b0111, 4'b0001, 1'b1);
        expect_rsp(2'd0, 5'd7);
        expect_rsp(2'd1, 5'd16);
        expect_rsp(2'd2, 5'b10001);
        expect_rsp(2'd3, 5'd9);
        expect_rsp(2'd0, 5'd16);
        wait_grants("rr_first", 1, 10);
        post(0, 4'b1111, 4'b0001, 1'b0);
        wait_drain("rr_drain", 60);
        chk("rr_count", 32'(glog.size()), 32'd5);
        if (glog.size() == 5) begin
            chk("rr_g0", 32'(glog[0]), 32'b0001);
            chk("rr_g1", 32'(glog[1]), 32'b0010);
            chk("rr_g2", 32'(glog[2]), 32'b0100);
            chk("rr_g3", 32'(glog[3]), 32'b1000);
            chk("rr_g4", 32'(glog[4]), 32'b0001);
            chk("rr_gap1", 32'(gcyc[1] - gcyc[0]), 32'd4);
            chk("rr_gap2", 32'(gcyc[2] - gcyc[1]), 32'd4);
        end

        // Backpressure in RESP; pointer now 1
        rsp_ready = 1'b0;
        post(1, 4'b0110, 4'b0011, 1'b0);
        post(2, 4'b0001, 4'b0001, 1'b1);
        expect_rsp(2'd1, 5'd9);
        expect_rsp(2'd2, 5'd3);
        begin
            int n;
            n = 0;
            while (!rsp_valid && n < 20) begin
                tick();
                n++;
            end
            chk("bp_reach_resp", 32'(rsp_valid), 32'd1);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_id", 32'(rsp_id), 32'd1);
            chk("bp_sum", 32'(rsp_sum), 32'd9);
            chk("bp_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        tick();
        chk("bp_next_grant", 32'(req_ready), 32'b0100);
        wait_drain("bp_drain", 30);

        // Wrap: pointer is 3, only requester 0 valid with max operands
        glog.delete();
        post(0, 4'b1111, 4'b1111, 1'b1);
        expect_rsp(2'd0, 5'b11111);
        wait_drain("wrap_drain", 20);
        post(1, 4'b0010, 4'b0010, 1'b0);
        post(0, 4'b0000, 4'b0000, 1'b0);
        expect_rsp(2'd1, 5'd4);
        expect_rsp(2'd0, 5'd0);
        wait_drain("wrap_drain2", 30);
        chk("wrap_count", 32'(glog.size()), 32'd3);
        if (glog.size() == 3) begin
            chk("wrap_g0", 32'(glog[0]), 32'b0001);
            chk("wrap_g1", 32'(glog[1]), 32'b0010);
            chk("wrap_g2", 32'(glog[2]), 32'b0001);
        end

        // Async reset while in WAIT; pointer was 1, grant 2 would move it to 3
        glog.delete();
        post(2, 4'b0100, 4'b0011, 1'b1);
        wait_grants("ar_grant", 1, 10);
        rst_n = 1'b0;
        #1;
        chk("ar_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("ar_req_ready", 32'(req_ready), 32'd0);
        chk("ar_add", 32'({add_a, add_b, add_cin}), 32'd0);
        chk("ar_rsp_id", 32'(rsp_id), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("ar_hold", 32'(rsp_valid), 32'd0);
        end
        rst_n = 1'b1;
        glog.delete();
        post(2, 4'b0100, 4'b0011, 1'b1);
        post(3, 4'b1001, 4'b0110, 1'b0);
        expect_rsp(2'd2, 5'd8);
        expect_rsp(2'd3, 5'd15);
        wait_drain("ar_drain", 30);
        chk("ar_count", 32'(glog.size()), 32'd2);
        if (glog.size() == 2) begin
            chk("ar_g0", 32'(glog[0]), 32'b0100);
            chk("ar_g1", 32'(glog[1]), 32'b1000);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
